// File: rtl/spiker_run_ctrl_if.sv
// Core timestep handshake and output-capture strobe
// between the run sequencer and the spiker core.
interface spiker_run_ctrl_if;
  logic core_start;
  logic core_done;
  logic sample;

  modport master (
    output core_start,
    output sample,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  sample,
    output core_done
  );
endinterface

// File: rtl/spiker_run_ctrl.sv
// Run sequencer: launches N timesteps on the spiker core,
// guards each with a watchdog, then samples and reports.
module spiker_run_ctrl #(
  parameter int unsigned N_STEP_W = 8,
  parameter int unsigned TO_W     = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [N_STEP_W-1:0] n_steps_i,
  input  logic [TO_W-1:0]     timeout_i,
  spiker_run_ctrl_if.master   core,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                irq_o,
  output logic [N_STEP_W-1:0] step_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [N_STEP_W-1:0] n_q;
  logic [N_STEP_W-1:0] cnt_q;
  logic [N_STEP_W-1:0] cnt_inc;
  logic [TO_W-1:0]     to_q;
  logic [TO_W-1:0]     wd_q;
  logic                done_q;
  logic                err_q;
  logic                irq_q;

  logic in_idle;
  logic in_wait;
  logic accept;
  logic wd_en;
  logic wd_exp;
  logic step_fire;
  logic to_fire;
  logic fin_set;
  logic last_step;

  assign in_idle   = (state_q == S_IDLE);
  assign in_wait   = (state_q == S_WAIT);
  assign accept    = in_idle && start_i
                   && (n_steps_i != '0);
  assign wd_en     = (to_q != '0);
  assign wd_exp    = wd_en && (wd_q == TO_W'(1));
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_step = (cnt_inc == n_q);

  // abort outranks both the done pulse and the watchdog
  assign step_fire = in_wait && core.core_done
                   && !abort_i;
  assign to_fire   = in_wait && !core.core_done
                   && wd_exp && !abort_i;
  assign fin_set   = (state_q == S_SAMPLE)
                   && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core.core_done) begin
          state_d = last_step ? S_SAMPLE
                              : S_LAUNCH;
        end else if (wd_exp) begin
          state_d = S_IDLE;
        end
      end
      S_SAMPLE: begin
        state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && !in_idle) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      to_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= fin_set || to_fire;
      if (accept) begin
        n_q    <= n_steps_i;
        to_q   <= timeout_i;
        cnt_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (state_q == S_LAUNCH) begin
        wd_q <= to_q;
      end else if (in_wait && wd_en
                   && !core.core_done) begin
        wd_q <= wd_q - 1'b1;
      end
      if (step_fire) cnt_q  <= cnt_inc;
      if (to_fire)   err_q  <= 1'b1;
      if (fin_set)   done_q <= 1'b1;
    end
  end

  assign core.core_start = (state_q == S_LAUNCH)
                         && !abort_i;
  assign core.sample     = (state_q == S_SAMPLE)
                         && !abort_i;
  assign busy_o          = !in_idle;
  assign done_o          = done_q;
  assign error_o         = err_q;
  assign irq_o           = irq_q;
  assign step_cnt_o      = cnt_q;

endmodule

// File: tb/tb_spiker_run_ctrl.sv
// Bench for spiker_run_ctrl: directed and random runs
// predicted from per-step latencies by cycle arithmetic.
module tb_spiker_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  n_steps;
  logic [15:0] timeout;
  logic        busy;
  logic        done;
  logic        err;
  logic        irq;
  logic [7:0]  step_cnt;

  int checks = 0;
  int errors = 0;
  int dly [1:16];

  always #5 clk = ~clk;

  spiker_run_ctrl_if cif ();

  spiker_run_ctrl #(
    .N_STEP_W(8),
    .TO_W(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .abort_i(abort),
    .n_steps_i(n_steps),
    .timeout_i(timeout),
    .core(cif.master),
    .busy_o(busy),
    .done_o(done),
    .error_o(err),
    .irq_o(irq),
    .step_cnt_o(step_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Expected timeline from step latencies: cycle 1 is the
  // first cycle after the accepting edge; step i launches at
  // prev_done+1 and its done lands dly[i] cycles later.
  task automatic run_case(input int n, input int t,
                          input int ab, input bit mid);
    int e_starts, e_cnt, e_scyc, e_icyc;
    int e_idle, e_done, e_err, launch, p;
    int cyc, starts, samples, irqs;
    int scyc, icyc, idle, pend;
    p = 0; e_scyc = 0; e_icyc = 0; e_done = 0;
    e_err = 0; e_starts = n; e_cnt = n; e_idle = 0;
    for (int i = 1; i <= n; i++) begin
      launch = p + 1;
      if (t != 0 && dly[i] > t) begin
        e_starts = i; e_cnt = i - 1; e_err = 1;
        e_icyc = launch + t + 1;
        e_idle = launch + t + 1;
        break;
      end
      if (ab == i) begin
        e_starts = i; e_cnt = i - 1;
        e_idle = launch + dly[i] + 1;
        break;
      end
      p = launch + dly[i];
    end
    if (e_idle == 0) begin
      e_scyc = p + 1; e_icyc = p + 2;
      e_idle = p + 3; e_done = 1;
    end

    @(negedge clk);
    start = 1'b1; n_steps = n[7:0];
    timeout = t[15:0]; abort = 1'b0;
    cif.core_done = 1'b0;
    cyc = 0; starts = 0; samples = 0; irqs = 0;
    scyc = 0; icyc = 0; idle = 0; pend = -1;
    while (idle == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0;
      cif.core_done = 1'b0;
      if (cyc == 1) begin
        chk("start_busy", 32'(busy), 1);
        chk("start_clr_err", 32'(err), 0);
        chk("start_clr_done", 32'(done), 0);
        chk("start_clr_cnt", 32'(step_cnt), 0);
      end
      if (cif.core_start) begin
        starts++;
        if (starts <= 16) pend = cyc + dly[starts];
      end
      if (cif.sample) begin samples++; scyc = cyc; end
      if (irq) begin irqs++; icyc = cyc; end
      if (!busy) begin
        idle = cyc;
      end else begin
        if (cyc == pend) begin
          cif.core_done = 1'b1;
          if (ab == starts) abort = 1'b1;
        end
        if (mid && cyc == 2) begin
          start = 1'b1; n_steps = 8'd1;
        end
      end
    end
    chk("run_budget", 32'(idle != 0), 1);
    chk("n_core_start", starts, e_starts);
    chk("n_sample", samples, (e_scyc != 0) ? 1 : 0);
    chk("sample_cycle", scyc, e_scyc);
    chk("n_irq", irqs, (e_icyc != 0) ? 1 : 0);
    chk("irq_cycle", icyc, e_icyc);
    chk("idle_cycle", idle, e_idle);
    chk("done_flag", 32'(done), e_done);
    chk("error_flag", 32'(err), e_err);
    chk("step_cnt", 32'(step_cnt), e_cnt);
  endtask

  initial begin
    int any;
    int n, t, ab;
    bit mid;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    n_steps = '0; timeout = '0;
    cif.core_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    any = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || err || irq
          || cif.core_start || cif.sample
          || step_cnt != 0) any++;
    end
    chk("reset_quiet", any, 0);
    chk("reset_cnt", 32'(step_cnt), 0);

    for (int i = 1; i <= 16; i++) dly[i] = 4;
    run_case(3, 0, 0, 1'b0);

    dly[1] = 5; dly[2] = 1000;
    run_case(2, 5, 0, 1'b0);

    @(negedge clk);
    start = 1'b1; n_steps = 8'd0; timeout = 16'd3;
    any = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || cif.core_start) any++;
    end
    chk("zero_n_busy", any, 0);
    chk("zero_n_err", 32'(err), 1);
    chk("zero_n_done", 32'(done), 0);
    chk("zero_n_cnt", 32'(step_cnt), 1);

    for (int i = 1; i <= 16; i++) dly[i] = 3;
    run_case(4, 0, 2, 1'b0);
    run_case(3, 6, 0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 6);
      t = ($urandom_range(0, 2) == 0)
        ? 0 : $urandom_range(1, 8);
      for (int i = 1; i <= 16; i++)
        dly[i] = $urandom_range(1, 9);
      ab = ($urandom_range(0, 3) == 0)
         ? $urandom_range(1, n) : 0;
      mid = 1'($urandom_range(0, 1));
      run_case(n, t, ab, mid);
    end

    // reset lands in WAIT of step 2
    @(negedge clk);
    start = 1'b1; n_steps = 8'd3; timeout = 16'd0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); cif.core_done = 1'b1;
    @(negedge clk); cif.core_done = 1'b0;
    chk("rst_seq_launch2", 32'(cif.core_start), 1);
    @(negedge clk);
    chk("rst_seq_cnt", 32'(step_cnt), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs",
        {25'd0, busy, done, err, irq,
         cif.core_start, cif.sample, 1'b0}, 0);
    chk("rst_mid_cnt", 32'(step_cnt), 0);
    rst = 1'b0;

    for (int i = 1; i <= 16; i++) dly[i] = 2;
    run_case(2, 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spiker_run_ctrl.md
# spiker_run_ctrl

Run sequencer for the spiker inference core. On a software start it launches the core for a programmed number of timesteps, handshaking each step through a start/done pulse pair and guarding each step with a watchdog. After the last step it fires the one-cycle sample strobe that captures the core's output bus into the status registers. It then reports completion or timeout through sticky flags and an interrupt pulse.

## Interface
- N_STEP_W, default 8: width of the timestep count.
- TO_W, default 16: width of the per-step watchdog count.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  run request; one-cycle pulse from the register interface.
- abort_i  in  1  cancels a run in progress.
- n_steps_i  in  N_STEP_W  timesteps per run; latched on an accepted start.
- timeout_i  in  TO_W  per-step watchdog limit in cycles; 0 disables the watchdog; latched on an accepted start.
- core_done_i  in  1  core finished the current timestep; one-cycle pulse.
- core_start_o  out  1  launches one timestep; one-cycle pulse.
- sample_o  out  1  one-cycle strobe that captures the output bus into the status registers.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  sticky; the last run completed normally.
- error_o  out  1  sticky; the last run ended in a watchdog timeout.
- irq_o  out  1  registered one-cycle pulse on completion or on timeout.
- step_cnt_o  out  N_STEP_W  number of completed timesteps in the current or last run.

## Operation
- States: IDLE, LAUNCH, WAIT, SAMPLE, FINISH.
- IDLE:
  - start_i with n_steps_i != 0 is accepted: latch n_steps_i and timeout_i, clear step_cnt, done_o and error_o, go to LAUNCH.
  - start_i with n_steps_i == 0 is ignored: no state change, no flag change.
- LAUNCH: core_start_o = 1; load the watchdog with the latched timeout; go to WAIT.
- WAIT, evaluated in this priority order:
  1. core_done_i = 1: step_cnt increments. If the new count equals the latched n_steps, go to SAMPLE; otherwise go to LAUNCH.
  2. Watchdog enabled and count == 1: set error_o, pulse irq_o, go to IDLE. No sample_o.
  3. Otherwise the watchdog decrements if enabled; stay in WAIT.
- SAMPLE: sample_o = 1; go to FINISH.
- FINISH: done_o set, irq_o pulses; go to IDLE.
- abort_i in any non-IDLE state:
  - Next state is IDLE.
  - Overrides every other transition, including core_done_i and watchdog expiry.
  - No sample_o, no irq_o; done_o and error_o stay 0; step_cnt holds.
- Ignored inputs:
  - start_i when not in IDLE.
  - core_done_i outside WAIT.
  - abort_i in IDLE.
- step_cnt cannot wrap, because a run ends exactly when the count reaches the latched n_steps (≤ 2^N_STEP_W − 1).
- Reset: state IDLE; core_start_o, sample_o, busy_o, done_o, error_o and irq_o all 0; step_cnt_o = 0; watchdog and latched values = 0.

## Timing
- Start accepted at edge E0:
  - LAUNCH occupies the cycle after E0, with core_start_o high.
  - WAIT begins on the next cycle.
- core_done_i in WAIT cycle k:
  - Not the last step: core_start_o is high in cycle k+1.
  - Last step: sample_o high in k+1; irq_o high and done_o rising in k+2; busy_o low from k+3.
- Watchdog with latched timeout T > 0:
  - core_done_i is accepted in WAIT cycles 1..T.
  - If none arrives, error_o and irq_o rise in cycle T+1, in IDLE.
  - core_done_i arriving in cycle T wins over the timeout.
- Per-step overhead is 1 cycle (LAUNCH) between a done pulse and the next start pulse.
- step_cnt_o updates on the edge that samples core_done_i.
- The register interface reads results no earlier than irq_o; the status registers are already valid in that cycle.
- busy_o is registered from the state, so it is high in the cycle following an accepted start_i.
- A new start_i is accepted in the first IDLE cycle after FINISH.

## Test plan
- Reset, then no stimulus for 20 cycles -> all outputs 0, state IDLE, step_cnt_o = 0.
- n_steps = 3, timeout = 0, core_done_i returned 4 cycles after each core_start_o:
  - exactly 3 core_start_o pulses;
  - sample_o once, 1 cycle after the third done;
  - irq_o 1 cycle after sample_o, done_o = 1, step_cnt_o = 3, error_o = 0.
- n_steps = 2, timeout = 5, first step done in cycle 5, second step never done:
  - first step completes normally;
  - error_o and irq_o rise in WAIT+6 of step 2;
  - no sample_o, step_cnt_o = 1, done_o = 0.
- n_steps = 4, abort_i asserted in the same cycle as the second core_done_i -> IDLE next cycle, step_cnt_o = 1, no sample_o, no irq_o, busy_o = 0.
- start_i with n_steps = 0 -> no change. start_i pulsed mid-run -> no effect on the count. A third run after a timeout run -> error_o clears on the accepted start.
- Reset asserted during WAIT of step 2 -> all outputs 0 on the next cycle. A subsequent start after reset runs normally.
